uart_rx_decoder: RTL and testbench
==================================

// Module: uart_rx_decoder
// PURPOSE
//  Receive-side counterpart of the UART transmit multiplexer. Pops bytes from the UART RX FIFO,
//  decodes the 3-bit message code in each byte, and updates per-function registers (game state,
//  shoot, score, mouse). Also tracks link health. Sits between uart_rx/FIFO and game logic.
//  Byte format: {code[7:5], payload[4:0]}.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  cycles without a byte before link_ok drops
//  TO_W            20         watchdog counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk             in   1   system clock
//  rst_n           in   1   asynchronous active-low reset
//  rx_empty        in   1   RX FIFO empty; r_data is the valid FIFO head when low
//  r_data          in   8   RX FIFO head byte
//  rd_uart         out  1   FIFO pop strobe, one cycle per byte
//  game_state      out  5   payload of last code 000
//  game_state_vld  out  1   1-cycle pulse on game_state update
//  shoot_dir       out  2   code-3 for last code 011..110 (0..3)
//  shoot_vld       out  1   1-cycle pulse on shoot_dir update
//  score           out  5   payload of last code 111
//  score_vld       out  1   1-cycle pulse on score update
//  mouse_pos       out  10  {hi payload (001), lo payload (010)}
//  mouse_vld       out  1   1-cycle pulse on mouse_pos update
//  pair_err        out  1   1-cycle pulse: code 010 received with no pending 001
//  link_ok         out  1   high while a byte arrived within TIMEOUT_CYCLES
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in IDLE; mouse pending flag clear; watchdog = TIMEOUT_CYCLES.
//  - FSM IDLE -> POP -> DECODE -> IDLE; all outputs are registered.
//    IDLE:   if !rx_empty, latch byte_q <= r_data and go to POP.
//    POP:    rd_uart = 1 for exactly this cycle; go to DECODE.
//    DECODE: decode byte_q; go to IDLE. rx_empty is not sampled in POP or DECODE.
//  - Latency: a *_vld pulse appears 3 cycles after the IDLE cycle that saw rx_empty = 0.
//    Maximum throughput is one byte per 3 cycles. The UART byte time is far longer.
//  - Decode rules; the value register and its vld pulse update on the same edge:
//    000        -> game_state.
//    011..110   -> shoot_dir = code - 3.
//    111        -> score.
//    001        -> hi_q <= payload; pending <= 1. A repeated 001 overwrites hi_q, no error.
//    010 with pending    -> mouse_pos <= {hi_q, payload}; mouse_vld; pending <= 0.
//    010 without pending -> byte discarded; pair_err pulse; mouse_pos unchanged.
//  - Other codes never clear pending. At most one *_vld or pair_err pulse per byte.
//  - Watchdog: counter reloads to 0 in DECODE for every byte. Otherwise it increments and
//    saturates at TIMEOUT_CYCLES. link_ok = (counter < TIMEOUT_CYCLES).
//    link_ok is 0 from reset until the first byte.
//  - Async reset mid-operation aborts any byte in flight. The byte is not re-read, and FIFO
//    contents are the FIFO's responsibility.
// CONFIGURATION
//  UART_RX_STATS_EN defined: adds outputs byte_cnt[15:0] and round_cnt[15:0].
//    byte_cnt  +1 per decoded byte.
//    round_cnt +1 per code 000.
//    Both wrap at 16 bits and reset to 0.
//  UART_RX_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - uart_pkg: typedef enum logic [2:0] msg_code_t
//      MSG_STATE=000, MSG_MOUSE_HI=001, MSG_MOUSE_LO=010, MSG_SHOOT_0..3=011..110, MSG_SCORE=111.
//  - uart_pkg: localparams CODE_MSB=7, PAYLOAD_W=5; typedef rx_state_t {IDLE, POP, DECODE}.
//  - Sub-module uart_link_watchdog (TIMEOUT_CYCLES, TO_W): inputs clk, rst_n, kick; output link_ok.
// TESTING
//  1. Reset release, FIFO empty for 10 cycles -> every output 0, rd_uart never high.
//  2. Push 8'b000_10101 -> one rd_uart pulse; 3 cycles later game_state = 5'h15 and game_state_vld = 1 for one cycle.
//  3. Push 8'h3F (001_11111), then 8'h40 (010_00000) -> mouse_pos = 10'h3E0 with one mouse_vld; pair_err stays 0.
//  4. From reset, push 8'h45 (010_00101) -> pair_err pulses; mouse_pos stays 0; mouse_vld stays 0.
//  5. Push 8'hA0 then 8'hFF -> shoot_dir = 2 with shoot_vld; then score = 5'h1F with score_vld.
//     Pulses are 3 cycles apart with a back-to-back FIFO.
//  6. TIMEOUT_CYCLES = 16: one byte, then idle -> link_ok = 1 after decode, 0 sixteen cycles later.
//     A new byte sets it back to 1.
//     With UART_RX_STATS_EN: byte_cnt = 1, then 2.

Source files
------------

// File: rtl/uart_rx_decoder_pkg.sv
// Shared message codes, field positions and receive FSM states for the UART RX decoder.
// Byte layout: {code[7:5], payload[4:0]}.
package uart_pkg;

  localparam int CODE_MSB  = 7;
  localparam int PAYLOAD_W = 5;

  typedef enum logic [2:0] {
    MSG_STATE    = 3'b000,
    MSG_MOUSE_HI = 3'b001,
    MSG_MOUSE_LO = 3'b010,
    MSG_SHOOT_0  = 3'b011,
    MSG_SHOOT_1  = 3'b100,
    MSG_SHOOT_2  = 3'b101,
    MSG_SHOOT_3  = 3'b110,
    MSG_SCORE    = 3'b111
  } msg_code_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    DECODE = 2'd2
  } rx_state_t;

endpackage

// File: rtl/uart_rx_decoder_if.sv
// FIFO read port between the UART RX FIFO (master) and the message decoder (slave).
interface uart_rx_decoder_if;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;

  modport master (output rx_empty, output r_data, input rd_uart);
  modport slave  (input rx_empty, input r_data, output rd_uart);
endinterface

// File: rtl/uart_rx_decoder_link_watchdog.sv
// Link-health watchdog: counts cycles since the last decoded byte, saturating at TIMEOUT_CYCLES.
// link_ok stays low from reset until the first kick.
module uart_link_watchdog #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kick,
  output logic link_ok
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= TO_MAX;
    end else if (kick) begin
      cnt <= '0;
    end else if (cnt < TO_MAX) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign link_ok = (cnt < TO_MAX);

endmodule

// File: rtl/uart_rx_decoder.sv
// Pops bytes from the UART RX FIFO, decodes the message code and updates game registers.
// Optional UART_RX_STATS_EN adds byte_cnt / round_cnt statistics outputs.
//
// state  | meaning
// IDLE   | wait for a non-empty FIFO, capture head byte
// POP    | rd_uart high for this cycle only
// DECODE | apply byte_q to the output registers, kick the watchdog
module uart_rx_decoder
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_W           = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_rx_decoder_if.slave     fifo,
  output logic [PAYLOAD_W-1:0] game_state,
  output logic                 game_state_vld,
  output logic [1:0]           shoot_dir,
  output logic                 shoot_vld,
  output logic [PAYLOAD_W-1:0] score,
  output logic                 score_vld,
  output logic [9:0]           mouse_pos,
  output logic                 mouse_vld,
  output logic                 pair_err,
  output logic                 link_ok
`ifdef UART_RX_STATS_EN
  ,
  output logic [15:0]          byte_cnt,
  output logic [15:0]          round_cnt
`endif
);

  rx_state_t             state, state_nxt;
  logic                  byte_ld, dec_en, rd_nxt, rd_q;
  logic [7:0]            byte_q;
  logic [PAYLOAD_W-1:0]  hi_q;
  logic                  pending;
  msg_code_t             code;
  logic [PAYLOAD_W-1:0]  payload;
  logic [2:0]            shoot_off;

  assign code      = msg_code_t'(byte_q[CODE_MSB -: 3]);
  assign payload   = byte_q[PAYLOAD_W-1:0];
  assign shoot_off = byte_q[CODE_MSB -: 3] - 3'd3;
  assign fifo.rd_uart = rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    byte_ld   = 1'b0;
    rd_nxt    = 1'b0;
    dec_en    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo.rx_empty) begin
          state_nxt = POP;
          byte_ld   = 1'b1;
          rd_nxt    = 1'b1;
        end
      end
      POP:     state_nxt = DECODE;
      DECODE: begin
        state_nxt = IDLE;
        dec_en    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rd_uart is registered so it is high exactly during the POP cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q <= '0;
      rd_q   <= 1'b0;
    end else begin
      rd_q <= rd_nxt;
      if (byte_ld) byte_q <= fifo.r_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      game_state     <= '0;
      game_state_vld <= 1'b0;
      shoot_dir      <= '0;
      shoot_vld      <= 1'b0;
      score          <= '0;
      score_vld      <= 1'b0;
      mouse_pos      <= '0;
      mouse_vld      <= 1'b0;
      pair_err       <= 1'b0;
      hi_q           <= '0;
      pending        <= 1'b0;
    end else begin
      game_state_vld <= 1'b0;
      shoot_vld      <= 1'b0;
      score_vld      <= 1'b0;
      mouse_vld      <= 1'b0;
      pair_err       <= 1'b0;
      if (dec_en) begin
        case (code)
          MSG_STATE: begin
            game_state     <= payload;
            game_state_vld <= 1'b1;
          end
          MSG_MOUSE_HI: begin
            hi_q    <= payload;
            pending <= 1'b1;
          end
          // a low half with no preceding high half is dropped
          MSG_MOUSE_LO: begin
            if (pending) begin
              mouse_pos <= {hi_q, payload};
              mouse_vld <= 1'b1;
              pending   <= 1'b0;
            end else begin
              pair_err <= 1'b1;
            end
          end
          MSG_SHOOT_0, MSG_SHOOT_1, MSG_SHOOT_2, MSG_SHOOT_3: begin
            shoot_dir <= shoot_off[1:0];
            shoot_vld <= 1'b1;
          end
          MSG_SCORE: begin
            score     <= payload;
            score_vld <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UART_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      round_cnt <= '0;
    end else if (dec_en) begin
      byte_cnt <= byte_cnt + 16'd1;
      if (code == MSG_STATE) round_cnt <= round_cnt + 16'd1;
    end
  end
`endif

  uart_link_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .kick    (dec_en),
    .link_ok (link_ok)
  );

endmodule

// File: tb/tb_uart_rx_decoder.sv
// Directed bench for uart_rx_decoder: FIFO model, scoreboard of expected pulses, fixed-latency and
// watchdog checks with TIMEOUT_CYCLES = 16.
module tb_uart_rx_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_decoder_if fifo_if ();

  logic [4:0]  game_state, score;
  logic [1:0]  shoot_dir;
  logic [9:0]  mouse_pos;
  logic        game_state_vld, shoot_vld, score_vld, mouse_vld, pair_err, link_ok;
`ifdef UART_RX_STATS_EN
  logic [15:0] byte_cnt, round_cnt;
`endif

  uart_rx_decoder #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo           (fifo_if),
    .game_state     (game_state),
    .game_state_vld (game_state_vld),
    .shoot_dir      (shoot_dir),
    .shoot_vld      (shoot_vld),
    .score          (score),
    .score_vld      (score_vld),
    .mouse_pos      (mouse_pos),
    .mouse_vld      (mouse_vld),
    .pair_err       (pair_err),
    .link_ok        (link_ok)
`ifdef UART_RX_STATS_EN
    ,
    .byte_cnt       (byte_cnt),
    .round_cnt      (round_cnt)
`endif
  );

  typedef struct {
    int         kind;   // 0 state, 1 shoot, 2 score, 3 mouse, 4 pair_err
    logic [9:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fq[$];
  int         pulse_t[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         rd_seen = 0;
  int         pushed = 0;
  int         m_bytes = 0;
  int         m_rounds = 0;
  logic       m_pend = 1'b0;
  logic [4:0] m_hi = '0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitor then FIFO model, both on the falling edge
  initial begin
    fifo_if.rx_empty = 1'b1;
    fifo_if.r_data   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        int   npulse;
        int   okind;
        logic [9:0] oval;
        exp_t e;
        npulse = int'(game_state_vld) + int'(shoot_vld) + int'(score_vld) + int'(mouse_vld) + int'(pair_err);
        if (fifo_if.rd_uart) rd_seen++;
        if (npulse != 0) begin
          check("one_pulse_per_byte", 16'(npulse), 16'd1);
          okind = game_state_vld ? 0 : shoot_vld ? 1 : score_vld ? 2 : mouse_vld ? 3 : 4;
          oval  = game_state_vld ? 10'(game_state) : shoot_vld ? 10'(shoot_dir) :
                  score_vld ? 10'(score) : mouse_vld ? mouse_pos : 10'd0;
          check("sb_has_entry", 16'(exp_q.size() != 0), 16'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_kind", 16'(okind), 16'(e.kind));
            check("sb_value", 16'(oval), 16'(e.val));
          end
          pulse_t.push_back(cyc);
        end
        if (fifo_if.rd_uart && fq.size() != 0) void'(fq.pop_front());
      end
      fifo_if.rx_empty = (fq.size() == 0);
      fifo_if.r_data   = (fq.size() != 0) ? fq[0] : 8'h00;
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic [2:0] c;
    logic [4:0] p;
    c = b[7:5];
    p = b[4:0];
    fq.push_back(b);
    pushed++;
    m_bytes++;
    case (c)
      3'd0: begin exp_q.push_back('{0, {5'd0, p}}); m_rounds++; end
      3'd1: begin m_hi = p; m_pend = 1'b1; end
      3'd2: begin
        if (m_pend) exp_q.push_back('{3, {m_hi, p}});
        else        exp_q.push_back('{4, 10'd0});
        m_pend = 1'b0;
      end
      3'd7:    exp_q.push_back('{2, {5'd0, p}});
      default: exp_q.push_back('{1, {8'd0, 2'(c - 3'd3)}});
    endcase
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    step(4);
    check(tag, 16'(exp_q.size() + fq.size()), 16'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fq.delete();
    exp_q.delete();
    m_pend = 1'b0;
    m_bytes = 0;
    m_rounds = 0;
    step(3);
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    // reset, FIFO idle
    do_reset();
    step(10);
    check("rst_game_state", 16'(game_state), 16'd0);
    check("rst_shoot_dir", 16'(shoot_dir), 16'd0);
    check("rst_score", 16'(score), 16'd0);
    check("rst_mouse_pos", 16'(mouse_pos), 16'd0);
    check("rst_pulses", 16'({game_state_vld, shoot_vld, score_vld, mouse_vld, pair_err}), 16'd0);
    check("rst_link_ok", 16'(link_ok), 16'd0);
    check("rst_rd_never", 16'(rd_seen), 16'd0);

    // single state byte: exact rd_uart / vld timing, then watchdog expiry
    push_byte(8'b000_10101);
    step(); check("lat_rd_n0", 16'(fifo_if.rd_uart), 16'd0);
    step(); check("lat_rd_n1", 16'(fifo_if.rd_uart), 16'd1);
    step(); check("lat_rd_n2", 16'(fifo_if.rd_uart), 16'd0);
            check("lat_vld_n2", 16'(game_state_vld), 16'd0);
    step(); check("lat_vld_n3", 16'(game_state_vld), 16'd1);
            check("lat_gs_n3", 16'(game_state), 16'h15);
            check("link_after_decode", 16'(link_ok), 16'd1);
    step(); check("lat_vld_n4", 16'(game_state_vld), 16'd0);
    step(14); check("link_k15", 16'(link_ok), 16'd1);
    step();   check("link_k16", 16'(link_ok), 16'd0);
`ifdef UART_RX_STATS_EN
    check("stats_byte_1", byte_cnt, 16'd1);
`endif
    push_byte(8'h07);
    drain("drain_relink");
    check("link_relink", 16'(link_ok), 16'd1);
`ifdef UART_RX_STATS_EN
    check("stats_byte_2", byte_cnt, 16'd2);
`endif

    // mouse pairing, lone low half, overwrite of high half, pending across other codes
    push_byte(8'h3F); push_byte(8'h40);
    drain("drain_mouse");
    check("mouse_3e0", 16'(mouse_pos), 16'h3E0);
    push_byte(8'h41);
    drain("drain_pair_after_clear");
    check("mouse_kept", 16'(mouse_pos), 16'h3E0);
    push_byte(8'h21); push_byte(8'h3E); push_byte(8'h43);
    drain("drain_overwrite");
    check("mouse_overwrite", 16'(mouse_pos), 16'h3C3);
    push_byte(8'h25); push_byte(8'h07); push_byte(8'h5A);
    drain("drain_interleave");
    check("mouse_interleave", 16'(mouse_pos), 16'h0BA);

    // shoot then score back-to-back: pulses 3 cycles apart
    n0 = pulse_t.size();
    push_byte(8'hA0); push_byte(8'hFF);
    drain("drain_shoot_score");
    check("shoot_2", 16'(shoot_dir), 16'd2);
    check("score_1f", 16'(score), 16'h1F);
    check("pulse_spacing", 16'(pulse_t.size() == n0 + 2 ? pulse_t[n0 + 1] - pulse_t[n0] : 0), 16'd3);
    push_byte(8'h60); push_byte(8'hD3); push_byte(8'h80);
    drain("drain_shoots");
    check("shoot_last", 16'(shoot_dir), 16'd1);
    check("rd_count", 16'(rd_seen), 16'(pushed));
`ifdef UART_RX_STATS_EN
    check("stats_bytes", byte_cnt, 16'(m_bytes));
    check("stats_rounds", round_cnt, 16'(m_rounds));
`endif

    // fresh reset: low half alone raises pair_err only
    do_reset();
    step(2);
    check("rst2_mouse", 16'(mouse_pos), 16'd0);
    push_byte(8'h45);
    drain("drain_pair_err");
    check("pair_mouse_zero", 16'(mouse_pos), 16'd0);
    check("rd_count_final", 16'(rd_seen), 16'(pushed));
`ifdef UART_RX_STATS_EN
    check("stats_after_rst", byte_cnt, 16'(m_bytes));
    check("rounds_after_rst", round_cnt, 16'(m_rounds));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
